// File: rtl/axi_read_arbiter.sv
// AXI read-channel arbiter: decodes ARADDR per master, arbitrates per slave, and holds each route until RLAST.
// Define AXI_READ_ARB_RR_EN for per-slave round-robin; without it, the lowest master index wins.
module axi_read_arbiter #(
  parameter int NUM_M     = 3,
  parameter int NUM_S     = 6,
  parameter int MIDX_BITS = 2,
  parameter int SIDX_BITS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_M-1:0]                ARVALID_M,
  input  logic [NUM_M-1:0][31:0]          ARADDR_M,
  input  logic [NUM_S+1:0]                ARREADY_S,
  input  logic [NUM_S+1:0]                RVALID_S,
  input  logic [NUM_S+1:0]                RLAST_S,
  input  logic [NUM_M:0]                  RREADY_M,
  output logic [NUM_S:0][MIDX_BITS-1:0]   SRIdx,
  output logic [NUM_M-1:0][SIDX_BITS-1:0] MRIdx,
  output logic [NUM_M-1:0]                busy_o
);

  localparam logic [MIDX_BITS-1:0] IDLE_M = MIDX_BITS'(NUM_M);
  localparam logic [SIDX_BITS-1:0] IDLE_S = SIDX_BITS'(NUM_S + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_AR_BUSY = 2'd1, ST_R_BUSY = 2'd2} state_t;

  state_t                          state_r     [NUM_M];
  state_t                          state_nxt_s [NUM_M];
  logic [NUM_S:0]                  slave_busy_r;
  logic [NUM_S:0]                  slave_busy_nxt_s;
  logic [NUM_S:0][MIDX_BITS-1:0]   sridx_nxt_s;
  logic [NUM_M-1:0][SIDX_BITS-1:0] mridx_nxt_s;
  logic [NUM_M-1:0][SIDX_BITS-1:0] target_s;
  logic [NUM_M-1:0]                ar_done_s;
  logic [NUM_M-1:0]                release_s;
  logic [NUM_M-1:0]                grant_m_s;
  logic [NUM_S:0][NUM_M-1:0]       req_s;
  logic [NUM_S:0]                  gnt_found_s;
  logic [NUM_S:0][MIDX_BITS-1:0]   gnt_win_s;
  logic [NUM_S:0]                  release_slv_s;
  logic [NUM_M-1:0][15:0]          addr_lo_unused_s;
  logic                            rready_idle_unused_s;
`ifdef AXI_READ_ARB_RR_EN
  logic [NUM_S:0][MIDX_BITS-1:0]   rr_r;
  logic [NUM_S:0][MIDX_BITS-1:0]   rr_nxt_s;
`endif

  // First requester found scanning from start, wrapping modulo NUM_M; returns {found, winner}.
  function automatic logic [MIDX_BITS:0] pick(input logic [NUM_M-1:0] req, input int start);
    logic                 found;
    logic [MIDX_BITS-1:0] win;
    int                   c;
    found = 1'b0;
    win   = {MIDX_BITS{1'b0}};
    for (int k = 0; k < NUM_M; k++) begin
      c     = (start + k) % NUM_M;
      win   = (!found && req[c]) ? MIDX_BITS'(c) : win;
      found = found | req[c];
    end
    return {found, win};
  endfunction

  assign rready_idle_unused_s = RREADY_M[NUM_M];

  // Address decode and per-master handshake detection on the locked route.
  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      addr_lo_unused_s[m] = ARADDR_M[m][15:0];
      if (ARADDR_M[m][31:16] < 16'(NUM_S)) begin
        target_s[m] = SIDX_BITS'(ARADDR_M[m][31:16]) + SIDX_BITS'(1);
      end else begin
        target_s[m] = {SIDX_BITS{1'b0}};
      end
      ar_done_s[m] = (state_r[m] == ST_AR_BUSY) && ARVALID_M[m] && ARREADY_S[MRIdx[m]];
      release_s[m] = (state_r[m] == ST_R_BUSY) && RVALID_S[MRIdx[m]] && RREADY_M[m]
                     && RLAST_S[MRIdx[m]];
    end
  end

  // Per-slave candidate collection and winner selection.
  always_comb begin
    req_s         = {((NUM_S+1)*NUM_M){1'b0}};
    gnt_found_s   = {(NUM_S+1){1'b0}};
    gnt_win_s     = {((NUM_S+1)*MIDX_BITS){1'b0}};
    release_slv_s = {(NUM_S+1){1'b0}};
    for (int s = 0; s <= NUM_S; s++) begin
      for (int m = 0; m < NUM_M; m++) begin
        req_s[s][m] = !slave_busy_r[s] && (state_r[m] == ST_IDLE) && ARVALID_M[m]
                      && (target_s[m] == SIDX_BITS'(s));
        release_slv_s[s] = release_slv_s[s] | (release_s[m] && (MRIdx[m] == SIDX_BITS'(s)));
      end
`ifdef AXI_READ_ARB_RR_EN
      {gnt_found_s[s], gnt_win_s[s]} = pick(req_s[s], int'(rr_r[s]));
`else
      {gnt_found_s[s], gnt_win_s[s]} = pick(req_s[s], 0);
`endif
    end
    for (int m = 0; m < NUM_M; m++) begin
      grant_m_s[m] = gnt_found_s[target_s[m]] && (gnt_win_s[target_s[m]] == MIDX_BITS'(m));
    end
  end

  // Next-state for master FSMs, route indices and slave locks.
  always_comb begin
    sridx_nxt_s      = SRIdx;
    mridx_nxt_s      = MRIdx;
    slave_busy_nxt_s = slave_busy_r;
    for (int m = 0; m < NUM_M; m++) begin
      state_nxt_s[m] = state_r[m];
      case (state_r[m])
        ST_IDLE: begin
          if (grant_m_s[m]) begin
            state_nxt_s[m] = ST_AR_BUSY;
            mridx_nxt_s[m] = target_s[m];
          end else begin
            state_nxt_s[m] = ST_IDLE;
          end
        end
        ST_AR_BUSY: begin
          if (ar_done_s[m]) begin
            state_nxt_s[m] = ST_R_BUSY;
          end else begin
            state_nxt_s[m] = ST_AR_BUSY;
          end
        end
        ST_R_BUSY: begin
          if (release_s[m]) begin
            state_nxt_s[m] = ST_IDLE;
            mridx_nxt_s[m] = IDLE_S;
          end else begin
            state_nxt_s[m] = ST_R_BUSY;
          end
        end
        default: begin
          state_nxt_s[m] = ST_IDLE;
          mridx_nxt_s[m] = IDLE_S;
        end
      endcase
    end
    // A slave is never released and granted together: its lock masks all candidates.
    for (int s = 0; s <= NUM_S; s++) begin
      if (release_slv_s[s]) begin
        slave_busy_nxt_s[s] = 1'b0;
        sridx_nxt_s[s]      = IDLE_M;
      end else if (gnt_found_s[s]) begin
        slave_busy_nxt_s[s] = 1'b1;
        sridx_nxt_s[s]      = gnt_win_s[s];
      end else begin
        slave_busy_nxt_s[s] = slave_busy_r[s];
        sridx_nxt_s[s]      = SRIdx[s];
      end
    end
  end

  // State, route and lock registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < NUM_M; m++) begin
        state_r[m] <= ST_IDLE;
      end
      SRIdx        <= {(NUM_S+1){IDLE_M}};
      MRIdx        <= {NUM_M{IDLE_S}};
      slave_busy_r <= {(NUM_S+1){1'b0}};
      busy_o       <= {NUM_M{1'b0}};
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        state_r[m] <= state_nxt_s[m];
        busy_o[m]  <= (state_nxt_s[m] != ST_IDLE);
      end
      SRIdx        <= sridx_nxt_s;
      MRIdx        <= mridx_nxt_s;
      slave_busy_r <= slave_busy_nxt_s;
    end
  end

`ifdef AXI_READ_ARB_RR_EN
  // Round-robin pointers advance past each slave's latest winner.
  always_comb begin
    for (int s = 0; s <= NUM_S; s++) begin
      rr_nxt_s[s] = gnt_found_s[s] ? MIDX_BITS'((int'(gnt_win_s[s]) + 1) % NUM_M) : rr_r[s];
    end
  end

  // Round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_r <= {((NUM_S+1)*MIDX_BITS){1'b0}};
    end else begin
      rr_r <= rr_nxt_s;
    end
  end
`endif

endmodule
